// File: rtl/risc_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory port, decode handshake and redirect.
// master is the fetch unit, slave is the memory/decode/branch side.
interface risc_fetch_queue_if #(
    parameter int AW = 30,
    parameter int IW = 32
);
    logic          IREQ;
    logic [AW-1:0] IADDR;
    logic [IW-1:0] INSTR;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [IW-1:0] OUT_INSTR;
    logic [AW-1:0] OUT_PC;
    logic          REDIR_VALID;
    logic [AW-1:0] REDIR_ADDR;

    modport master (
        output IREQ, IADDR, OUT_VALID, OUT_INSTR, OUT_PC,
        input  INSTR, OUT_READY, REDIR_VALID, REDIR_ADDR
    );

    modport slave (
        input  IREQ, IADDR, OUT_VALID, OUT_INSTR, OUT_PC,
        output INSTR, OUT_READY, REDIR_VALID, REDIR_ADDR
    );
endinterface

// File: rtl/risc_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues memory requests
// under credit control and buffers returned words in a prefetch queue.
module risc_fetch_queue #(
    parameter int            AW         = 30,
    parameter int            IW         = 32,
    parameter int            DEPTH      = 4,
    parameter int            IMEM_LAT   = 1,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input  logic CLK,
    input  logic RSTN,
    risc_fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic          run;
    logic [AW-1:0] fetch_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [IW-1:0] q_instr [DEPTH];
    logic [AW-1:0] q_pc    [DEPTH];
    logic          fl_v    [IMEM_LAT];
    logic [AW-1:0] fl_pc   [IMEM_LAT];

    logic          redir;
    logic          issue;
    logic          push;
    logic          pop;
    logic          out_valid;
    logic [CW:0]   used;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits cover both buffered and in-flight words, so the queue never overflows.
    assign redir     = bus.REDIR_VALID;
    assign used      = {1'b0, count} + {1'b0, inflight};
    assign issue     = run & ~redir & (used < (CW + 1)'(DEPTH));
    assign push      = fl_v[IMEM_LAT-1];
    assign out_valid = (count != '0);
    assign pop       = out_valid & bus.OUT_READY;

    assign bus.IREQ      = issue;
    assign bus.IADDR     = fetch_pc;
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_INSTR = q_instr[rptr];
    assign bus.OUT_PC    = q_pc[rptr];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            run      <= 1'b0;
            fetch_pc <= RESET_ADDR;
            count    <= '0;
            inflight <= '0;
            rptr     <= '0;
            wptr     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
            for (int i = 0; i < IMEM_LAT; i++) begin
                fl_v[i]  <= 1'b0;
                fl_pc[i] <= '0;
            end
        end else begin
            run      <= 1'b1;
            fl_v[0]  <= issue;
            fl_pc[0] <= fetch_pc;
            for (int i = 1; i < IMEM_LAT; i++) begin
                fl_v[i]  <= fl_v[i-1];
                fl_pc[i] <= fl_pc[i-1];
            end
            if (redir) begin
                // Late responses are killed by clearing their valid bits.
                fetch_pc <= bus.REDIR_ADDR;
                count    <= '0;
                inflight <= '0;
                rptr     <= '0;
                wptr     <= '0;
                for (int i = 0; i < IMEM_LAT; i++) begin
                    fl_v[i] <= 1'b0;
                end
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + AW'(1);
                end
                count    <= count + CW'(push) - CW'(pop);
                inflight <= inflight + CW'(issue) - CW'(push);
                if (push) begin
                    q_instr[wptr] <= bus.INSTR;
                    q_pc[wptr]    <= fl_pc[IMEM_LAT-1];
                    wptr          <= wrap_inc(wptr);
                end
                if (pop) begin
                    rptr <= wrap_inc(rptr);
                end
            end
        end
    end
endmodule

// File: tb/tb_risc_fetch_queue.sv
// Bench for risc_fetch_queue: three configurations in lockstep, each checked
// against a transaction-level queue model with availability timestamps.
module tb_risc_fetch_queue;
    localparam int NI = 3;

    typedef struct {
        logic [29:0] pc;
        int          av;
    } ent_t;

    logic          clk;
    logic          rstn;
    logic [NI-1:0] rdy;
    logic [NI-1:0] rv;
    logic [29:0]   ra      [NI];
    logic [NI-1:0] ireq_w;
    logic [NI-1:0] ov_w;
    logic [29:0]   iaddr_w [NI];
    logic [29:0]   opc_w   [NI];
    logic [31:0]   oins_w  [NI];

    int          vectors;
    int          miscompares;
    int          cyc;
    ent_t        q [NI][$];
    logic [29:0] exp_ia [NI];
    bit          run_m  [NI];

    function automatic int lat_of(input int g);
        return (g == 2) ? 3 : 1;
    endfunction

    function automatic int dep_of(input int g);
        return (g == 2) ? 5 : 4;
    endfunction

    function automatic logic [29:0] ra_of(input int g);
        return (g == 1) ? 30'h3FFF_FFFE : 30'h0;
    endfunction

    function automatic logic [31:0] fmem(input logic [29:0] a);
        return {2'b10, a};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int          LAT = (g == 2) ? 3 : 1;
        localparam int          DEP = (g == 2) ? 5 : 4;
        localparam logic [29:0] RA  = (g == 1) ? 30'h3FFF_FFFE : 30'h0;

        risc_fetch_queue_if #(.AW(30), .IW(32)) bus ();

        risc_fetch_queue #(
            .AW(30), .IW(32), .DEPTH(DEP),
            .IMEM_LAT(LAT), .RESET_ADDR(RA)
        ) dut (
            .CLK (clk),
            .RSTN(rstn),
            .bus (bus)
        );

        logic        mv [LAT];
        logic [29:0] ma [LAT];
        logic [31:0] garb;

        // Memory returns fmem(addr) exactly LAT cycles after the request, junk otherwise.
        always @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int i = 0; i < LAT; i++) begin
                    mv[i] <= 1'b0;
                    ma[i] <= '0;
                end
                garb <= '0;
            end else begin
                mv[0] <= bus.IREQ;
                ma[0] <= bus.IADDR;
                for (int i = 1; i < LAT; i++) begin
                    mv[i] <= mv[i-1];
                    ma[i] <= ma[i-1];
                end
                garb <= $urandom;
            end
        end

        assign bus.INSTR       = mv[LAT-1] ? fmem(ma[LAT-1]) : garb;
        assign bus.OUT_READY   = rdy[g];
        assign bus.REDIR_VALID = rv[g];
        assign bus.REDIR_ADDR  = ra[g];
        assign ireq_w[g]       = bus.IREQ;
        assign ov_w[g]         = bus.OUT_VALID;
        assign iaddr_w[g]      = bus.IADDR;
        assign opc_w[g]        = bus.OUT_PC;
        assign oins_w[g]       = bus.OUT_INSTR;
    end

    task automatic chk(input string tag, input int g,
                       input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d] cyc=%0d observed=%0h expected=%0h",
                   tag, g, cyc, obs, exp);
        end
    endtask

    task automatic check_reset(input int g);
        chk("rst_ireq", g, 64'(ireq_w[g]), 64'(0));
        chk("rst_iaddr", g, 64'(iaddr_w[g]), 64'(ra_of(g)));
        chk("rst_ovalid", g, 64'(ov_w[g]), 64'(0));
        chk("rst_opc", g, 64'(opc_w[g]), 64'(0));
        chk("rst_oinstr", g, 64'(oins_w[g]), 64'(0));
        q[g].delete();
        run_m[g]  = 1'b0;
        exp_ia[g] = ra_of(g);
    endtask

    task automatic check_all();
        bit   ov_e;
        bit   ireq_e;
        ent_t e;
        for (int g = 0; g < NI; g++) begin
            if (!rstn) begin
                check_reset(g);
                continue;
            end
            ov_e   = (q[g].size() > 0) && (q[g][0].av <= cyc);
            ireq_e = run_m[g] && !rv[g] && (q[g].size() < dep_of(g));
            chk("ireq", g, 64'(ireq_w[g]), 64'(ireq_e));
            if (ireq_e) chk("iaddr", g, 64'(iaddr_w[g]), 64'(exp_ia[g]));
            chk("ovalid", g, 64'(ov_w[g]), 64'(ov_e));
            if (ov_e) begin
                chk("opc", g, 64'(opc_w[g]), 64'(q[g][0].pc));
                chk("oinstr", g, 64'(oins_w[g]), 64'(fmem(q[g][0].pc)));
            end
            if (ov_e && rdy[g]) void'(q[g].pop_front());
            if (rv[g]) begin
                q[g].delete();
                exp_ia[g] = ra[g];
            end else if (ireq_e) begin
                e.pc = exp_ia[g];
                e.av = cyc + lat_of(g) + 1;
                q[g].push_back(e);
                exp_ia[g] = exp_ia[g] + 30'd1;
            end
            run_m[g] = 1'b1;
        end
        cyc++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            check_all();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rstn        = 1'b0;
        rdy         = '0;
        rv          = '0;
        for (int g = 0; g < NI; g++) begin
            ra[g]     = '0;
            exp_ia[g] = ra_of(g);
            run_m[g]  = 1'b0;
        end
        @(posedge clk);
        #1;
        tick(2);

        rstn = 1'b1;
        rdy  = '1;
        tick(14);

        rdy = '0;
        tick(10);
        rdy = '1;
        tick(12);

        rv    = '1;
        ra[0] = 30'h100;
        ra[1] = 30'h200;
        ra[2] = 30'h100;
        tick(1);
        rv = '0;
        tick(8);

        rv    = '1;
        ra[0] = 30'h50;
        ra[1] = 30'h3FFF_FFFF;
        ra[2] = 30'h50;
        tick(1);
        ra[0] = 30'h60;
        ra[1] = 30'h60;
        ra[2] = 30'h60;
        tick(1);
        rv = '0;
        tick(10);

        rdy = '0;
        tick(4);
        rv    = '1;
        ra[0] = 30'h123;
        ra[1] = 30'h3FFF_FFFD;
        ra[2] = 30'h777;
        tick(1);
        rv  = '0;
        rdy = '1;
        tick(10);

        rdy = '0;
        tick(8);
        #1;
        rstn = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) check_reset(g);
        @(posedge clk);
        #1;
        tick(2);
        rstn = 1'b1;
        rdy  = '1;
        tick(12);

        for (int k = 0; k < 400; k++) begin
            for (int g = 0; g < NI; g++) begin
                rdy[g] = ($urandom_range(0, 3) != 0);
                rv[g]  = ($urandom_range(0, 19) == 0);
                ra[g]  = $urandom_range(0, 1) ? 30'h3FFF_FFFC + 30'($urandom_range(0, 3))
                                              : 30'($urandom);
            end
            tick(1);
        end
        rv  = '0;
        rdy = '1;
        tick(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
